// File: rtl/oled128_spi_seq.sv
// Purpose : sequences the OLED128 panel over PMOD JB: timed hardware reset, then
//           byte-wise SPI mode-0 transmission with a per-byte DC (command/data) select.
// Latency : a byte occupies 17*CLK_DIV cycles from acceptance to the next tx_ready;
//           SCK first rises CLK_DIV cycles after acceptance.
// Backpressure: tx_ready is high only in READY; the byte is taken on tx_valid & tx_ready,
//           and tx_valid in any other state is dropped (no queueing).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start_init        one-cycle pulse: start/restart the panel reset sequence
//   tx_valid/tx_ready byte handshake; tx_data (MSB first) and tx_dc sampled on acceptance
//   init_done         panel reset sequence complete
//   oled_rst/oled_dc/oled_cs_n/oled_sck/oled_mosi  panel pins, all driven from flops
//   status            {16'hC0DE, 8'd0, byte_count[3:0], state[3:0]}
module oled128_spi_seq #(
  parameter int CLK_DIV         = 4,
  parameter int RST_LOW_CYCLES  = 1000,
  parameter int RST_WAIT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_init,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_dc,
  output logic        tx_ready,
  output logic        init_done,
  output logic        oled_rst,
  output logic        oled_dc,
  output logic        oled_cs_n,
  output logic        oled_sck,
  output logic        oled_mosi,
  output logic [31:0] status
);

  localparam int MAX_AB = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int MAXP   = (MAX_AB > CLK_DIV) ? MAX_AB : CLK_DIV;
  localparam int CW     = $clog2(MAXP + 1);

  // RST_LOW is entered on the start_init edge and leaves when the counter reaches
  // RST_LOW_CYCLES, so the pin reads low for RST_LOW_CYCLES edges after the start edge.
  localparam logic [CW-1:0] LOW_LAST  = CW'(RST_LOW_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  // GAP ends one cycle early so tx_ready is visible at the edge where cs_n has been
  // high for CLK_DIV cycles, letting a held tx_valid start the next byte right there.
  localparam logic [CW-1:0] GAP_LAST  = CW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  typedef enum logic [3:0] {
    S_HOLD     = 4'd0,
    S_RST_LOW  = 4'd1,
    S_RST_WAIT = 4'd2,
    S_READY    = 4'd3,
    S_SHIFT    = 4'd4,
    S_GAP      = 4'd5
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     half, half_nxt;        // SCK half-period index 0..15 within a byte
  logic [7:0]     sreg, sreg_nxt;
  logic [3:0]     byte_count, byte_count_nxt;
  logic           tx_ready_nxt, init_done_nxt;
  logic           oled_rst_nxt, oled_dc_nxt, oled_cs_n_nxt, oled_sck_nxt, oled_mosi_nxt;
  logic           restart_ok;

  assign status = {16'hC0DE, 8'd0, byte_count, state};

  // A byte in flight always completes, so start_init is only honoured outside SHIFT/GAP.
  assign restart_ok = (state != S_SHIFT) && (state != S_GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HOLD;
      cnt        <= '0;
      half       <= '0;
      sreg       <= '0;
      byte_count <= '0;
      tx_ready   <= 1'b0;
      init_done  <= 1'b0;
      oled_rst   <= 1'b0;
      oled_dc    <= 1'b0;
      oled_cs_n  <= 1'b1;
      oled_sck   <= 1'b0;
      oled_mosi  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      half       <= half_nxt;
      sreg       <= sreg_nxt;
      byte_count <= byte_count_nxt;
      tx_ready   <= tx_ready_nxt;
      init_done  <= init_done_nxt;
      oled_rst   <= oled_rst_nxt;
      oled_dc    <= oled_dc_nxt;
      oled_cs_n  <= oled_cs_n_nxt;
      oled_sck   <= oled_sck_nxt;
      oled_mosi  <= oled_mosi_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    half_nxt       = half;
    sreg_nxt       = sreg;
    byte_count_nxt = byte_count;
    tx_ready_nxt   = tx_ready;
    init_done_nxt  = init_done;
    oled_rst_nxt   = oled_rst;
    oled_dc_nxt    = oled_dc;
    oled_cs_n_nxt  = oled_cs_n;
    oled_sck_nxt   = oled_sck;
    oled_mosi_nxt  = oled_mosi;

    if (start_init && restart_ok) begin
      // Takes priority over tx_valid in READY.
      state_nxt     = S_RST_LOW;
      cnt_nxt       = '0;
      oled_rst_nxt  = 1'b0;
      tx_ready_nxt  = 1'b0;
      init_done_nxt = 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          oled_rst_nxt = 1'b0;
          tx_ready_nxt = 1'b0;
        end

        S_RST_LOW: begin
          if (cnt == LOW_LAST) begin
            state_nxt    = S_RST_WAIT;
            cnt_nxt      = '0;
            oled_rst_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_RST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state_nxt     = S_READY;
            cnt_nxt       = '0;
            tx_ready_nxt  = 1'b1;
            init_done_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_READY: begin
          if (tx_valid) begin
            state_nxt     = S_SHIFT;
            cnt_nxt       = '0;
            half_nxt      = '0;
            sreg_nxt      = tx_data;
            oled_dc_nxt   = tx_dc;
            oled_cs_n_nxt = 1'b0;
            oled_sck_nxt  = 1'b0;
            oled_mosi_nxt = tx_data[7];
            tx_ready_nxt  = 1'b0;
          end
        end

        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt_nxt      = '0;
            half_nxt     = half + 4'd1;
            oled_sck_nxt = ~oled_sck;
            // Odd half index = falling edge of SCK.
            if (half[0]) begin
              if (half == 4'd15) begin
                oled_cs_n_nxt = 1'b1;
                oled_sck_nxt  = 1'b0;
                if (CLK_DIV == 1) begin
                  // Single-cycle gap: the cs_n-high cycle is the one after this edge.
                  state_nxt      = S_READY;
                  tx_ready_nxt   = 1'b1;
                  byte_count_nxt = byte_count + 4'd1;
                end else begin
                  state_nxt = S_GAP;
                end
              end else begin
                sreg_nxt      = {sreg[6:0], 1'b0};
                oled_mosi_nxt = sreg[6];
              end
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt      = S_READY;
            cnt_nxt        = '0;
            tx_ready_nxt   = 1'b1;
            byte_count_nxt = byte_count + 4'd1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled128_spi_seq.sv
// Purpose : directed self-checking bench for oled128_spi_seq (CLK_DIV=2, 10/20 reset cycles).
// Latency : outputs observed 1 time unit after each rising edge ("after edge N").
// Backpressure: bytes are offered only when tx_ready is observed high.
module tb_oled128_spi_seq;

  localparam int CLK_DIV = 2;
  localparam int RLOW    = 10;
  localparam int RWAIT   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_init;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        tx_ready;
  logic        init_done;
  logic        oled_rst;
  logic        oled_dc;
  logic        oled_cs_n;
  logic        oled_sck;
  logic        oled_mosi;
  logic [31:0] status;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_count = 4'd0;

  oled128_spi_seq #(
    .CLK_DIV(CLK_DIV), .RST_LOW_CYCLES(RLOW), .RST_WAIT_CYCLES(RWAIT)
  ) dut (
    .clk(clk), .rst(rst), .start_init(start_init),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready),
    .init_done(init_done), .oled_rst(oled_rst), .oled_dc(oled_dc),
    .oled_cs_n(oled_cs_n), .oled_sck(oled_sck), .oled_mosi(oled_mosi),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and follows it until tx_ready returns (or 40 edges pass).
  // Edge numbers are relative to the acceptance edge E0.
  task automatic run_byte(input logic [7:0] d, input logic dc, input bit hold, input int init_at,
                          output logic [7:0] cap, output int rises, output int bad_pos,
                          output int cs_bad, output int dc_bad, output int ready_edge,
                          output bit acc);
    logic prev_sck;
    cap = 8'h00; rises = 0; bad_pos = 0; cs_bad = 0; dc_bad = 0; ready_edge = -1;
    tx_valid = 1'b1; tx_data = d; tx_dc = dc;
    step();
    acc = (oled_cs_n === 1'b0) && (oled_mosi === d[7]) && (tx_ready === 1'b0)
          && (oled_sck === 1'b0) && (status[3:0] === 4'd4);
    if (!hold) begin
      tx_valid = 1'b0; tx_data = ~d; tx_dc = ~dc;
    end
    prev_sck = oled_sck;
    for (int e = 1; e <= 40; e++) begin
      start_init = (e == init_at);
      step();
      if (oled_cs_n !== ((e >= 16*CLK_DIV) ? 1'b1 : 1'b0)) cs_bad++;
      if (oled_dc !== dc) dc_bad++;
      if (prev_sck === 1'b0 && oled_sck === 1'b1) begin
        rises++;
        cap = {cap[6:0], oled_mosi};
        if ((e % (2*CLK_DIV)) != CLK_DIV) bad_pos++;
      end
      prev_sck = oled_sck;
      if (tx_ready === 1'b1) begin
        ready_edge = e;
        break;
      end
    end
    start_init = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_init = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_dc = 1'b0;
    step(); step();
    checks++; if (oled_rst !== 1'b0)  begin failures++; $display("FAIL reset_oled_rst got=%b exp=0", oled_rst); end
    checks++; if (oled_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", oled_cs_n); end
    checks++; if ({oled_sck, oled_mosi, oled_dc} !== 3'b000) begin failures++; $display("FAIL reset_sck_mosi_dc got=%b exp=000", {oled_sck, oled_mosi, oled_dc}); end
    checks++; if ({tx_ready, init_done} !== 2'b00) begin failures++; $display("FAIL reset_ready_done got=%b exp=00", {tx_ready, init_done}); end
    checks++; if (status !== 32'hC0DE0000) begin failures++; $display("FAIL reset_status got=%h exp=c0de0000", status); end
  endtask

  task automatic test_idle_hold();
    int viol = 0;
    rst = 1'b0;
    tx_valid = 1'b1; tx_data = 8'hAA; tx_dc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (oled_sck !== 1'b0 || oled_cs_n !== 1'b1 || tx_ready !== 1'b0 || status[3:0] !== 4'd0) viol++;
    end
    tx_valid = 1'b0;
    checks++; if (viol != 0) begin failures++; $display("FAIL idle_hold_activity got=%0d exp=0", viol); end
  endtask

  task automatic test_init();
    int rst_bad = 0;
    int rdy_bad = 0;
    start_init = 1'b1;
    step();                      // edge 0
    start_init = 1'b0;
    checks++; if (status[3:0] !== 4'd1 || oled_rst !== 1'b0) begin failures++; $display("FAIL init_enter got=state %0d rst %b exp=state 1 rst 0", status[3:0], oled_rst); end
    for (int e = 1; e <= RLOW + RWAIT + 1; e++) begin
      step();
      if (oled_rst !== ((e >= RLOW + 1) ? 1'b1 : 1'b0)) rst_bad++;
      if ({tx_ready, init_done} !== ((e >= RLOW + RWAIT + 1) ? 2'b11 : 2'b00)) rdy_bad++;
    end
    checks++; if (rst_bad != 0) begin failures++; $display("FAIL init_oled_rst_timing got=%0d bad edges exp=0", rst_bad); end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL init_ready_timing got=%0d bad edges exp=0", rdy_bad); end
    checks++; if (status !== 32'hC0DE0003) begin failures++; $display("FAIL init_status got=%h exp=c0de0003", status); end
  endtask

  task automatic test_single_cmd();
    logic [7:0] cap; int rises, bad_pos, cs_bad, dc_bad, rdy; bit acc;
    run_byte(8'hAF, 1'b0, 1'b0, 0, cap, rises, bad_pos, cs_bad, dc_bad, rdy, acc);
    exp_count = exp_count + 4'd1;
    checks++; if (!acc)          begin failures++; $display("FAIL cmd_accept got=0 exp=1"); end
    checks++; if (cap !== 8'hAF) begin failures++; $display("FAIL cmd_mosi got=%h exp=af", cap); end
    checks++; if (rises != 8 || bad_pos != 0) begin failures++; $display("FAIL cmd_sck_edges got=%0d rises %0d misplaced exp=8 rises 0 misplaced", rises, bad_pos); end
    checks++; if (cs_bad != 0 || dc_bad != 0) begin failures++; $display("FAIL cmd_cs_dc got=cs %0d dc %0d exp=0 0", cs_bad, dc_bad); end
    checks++; if (rdy != 17*CLK_DIV - 1) begin failures++; $display("FAIL cmd_ready_edge got=%0d exp=%0d", rdy, 17*CLK_DIV - 1); end
    checks++; if (status[7:4] !== exp_count) begin failures++; $display("FAIL cmd_byte_count got=%0d exp=%0d", status[7:4], exp_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cap1, cap2; int r1, r2, p1, p2, c1, c2, d1, d2, y1, y2; bit a1, a2;
    run_byte(8'h00, 1'b1, 1'b1, 0, cap1, r1, p1, c1, d1, y1, a1);
    run_byte(8'hFF, 1'b1, 1'b0, 0, cap2, r2, p2, c2, d2, y2, a2);
    exp_count = exp_count + 4'd2;
    // a2 is sampled one edge after y1, i.e. the second byte starts at E0+17*CLK_DIV.
    checks++; if (!(a1 && a2 && y1 == 17*CLK_DIV - 1)) begin failures++; $display("FAIL b2b_accept got=a1 %0d a2 %0d rdy %0d exp=1 1 %0d", a1, a2, y1, 17*CLK_DIV - 1); end
    checks++; if (cap1 !== 8'h00 || cap2 !== 8'hFF) begin failures++; $display("FAIL b2b_data got=%h %h exp=00 ff", cap1, cap2); end
    checks++; if (c1 + c2 + d1 + d2 + p1 + p2 != 0 || r1 + r2 != 16) begin failures++; $display("FAIL b2b_pins got=cs %0d dc %0d pos %0d rises %0d exp=0 0 0 16", c1 + c2, d1 + d2, p1 + p2, r1 + r2); end
    checks++; if (status[7:4] !== exp_count) begin failures++; $display("FAIL b2b_byte_count got=%0d exp=%0d", status[7:4], exp_count); end
  endtask

  task automatic test_start_init_shift();
    logic [7:0] cap; int rises, bad_pos, cs_bad, dc_bad, rdy; bit acc;
    run_byte(8'h5A, 1'b1, 1'b0, 5, cap, rises, bad_pos, cs_bad, dc_bad, rdy, acc);
    exp_count = exp_count + 4'd1;
    checks++; if (cap !== 8'h5A || rises != 8 || cs_bad != 0) begin failures++; $display("FAIL init_in_shift_byte got=%h rises %0d cs %0d exp=5a 8 0", cap, rises, cs_bad); end
    checks++; if (rdy != 17*CLK_DIV - 1 || init_done !== 1'b1 || oled_rst !== 1'b1) begin failures++; $display("FAIL init_in_shift_ignored got=rdy %0d done %b rst %b exp=%0d 1 1", rdy, init_done, oled_rst, 17*CLK_DIV - 1); end
  endtask

  task automatic test_start_init_ready();
    int rst_bad = 0;
    int act_bad = 0;
    start_init = 1'b1; tx_valid = 1'b1; tx_data = 8'h33; tx_dc = 1'b1;
    step();                      // edge S
    start_init = 1'b0; tx_valid = 1'b0;
    checks++; if ({tx_ready, init_done, oled_rst, oled_cs_n} !== 4'b0001 || status[3:0] !== 4'd1) begin failures++; $display("FAIL init_in_ready_enter got=%b state %0d exp=0001 state 1", {tx_ready, init_done, oled_rst, oled_cs_n}, status[3:0]); end
    for (int e = 1; e <= RLOW + RWAIT + 1; e++) begin
      step();
      if (oled_rst !== ((e >= RLOW + 1) ? 1'b1 : 1'b0)) rst_bad++;
      if (oled_sck !== 1'b0 || oled_cs_n !== 1'b1) act_bad++;
    end
    checks++; if (rst_bad != 0) begin failures++; $display("FAIL reinit_rst_timing got=%0d bad edges exp=0", rst_bad); end
    checks++; if (act_bad != 0) begin failures++; $display("FAIL reinit_no_byte got=%0d bad edges exp=0", act_bad); end
    checks++; if (status !== {16'hC0DE, 8'd0, exp_count, 4'd3} || init_done !== 1'b1) begin failures++; $display("FAIL reinit_status got=%h done %b exp=%h 1", status, init_done, {16'hC0DE, 8'd0, exp_count, 4'd3}); end
  endtask

  task automatic test_rst_mid_byte();
    int act = 0;
    tx_valid = 1'b1; tx_data = 8'hC3; tx_dc = 1'b1;
    step();                      // E0
    tx_valid = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    rst = 1'b1;
    step();                      // E0+9
    rst = 1'b0;
    exp_count = 4'd0;
    checks++; if ({oled_cs_n, oled_sck, oled_rst, tx_ready} !== 4'b1000) begin failures++; $display("FAIL rst_mid_pins got=%b exp=1000", {oled_cs_n, oled_sck, oled_rst, tx_ready}); end
    checks++; if (status !== 32'hC0DE0000) begin failures++; $display("FAIL rst_mid_status got=%h exp=c0de0000", status); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (oled_sck !== 1'b0 || oled_cs_n !== 1'b1) act++;
    end
    checks++; if (act != 0) begin failures++; $display("FAIL rst_mid_no_sck got=%0d exp=0", act); end
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    for (int e = 1; e <= RLOW + RWAIT + 1; e++) step();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_reinit got=%b exp=1", tx_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] cap; int rises, bad_pos, cs_bad, dc_bad, rdy; bit acc;
    int bad = 0;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 1);
      run_byte(d, i[0], 1'b0, 0, cap, rises, bad_pos, cs_bad, dc_bad, rdy, acc);
      exp_count = exp_count + 4'd1;
      if (cap !== d || !acc || rdy != 17*CLK_DIV - 1) bad++;
      if (i == 14) begin
        checks++; if (status[7:4] !== 4'd15) begin failures++; $display("FAIL wrap_count15 got=%0d exp=15", status[7:4]); end
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_bytes got=%0d bad bytes exp=0", bad); end
    checks++; if (status[7:4] !== 4'd0 || exp_count !== 4'd0) begin failures++; $display("FAIL wrap_count0 got=%0d exp=0", status[7:4]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_hold();
    test_init();
    test_single_cmd();
    test_back_to_back();
    test_start_init_shift();
    test_start_init_ready();
    test_rst_mid_byte();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
